// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for a systolic array: for each tile it waits for the row FIFOs, issues a
// PE_SIZE-cycle en burst, covers the row-skew delay and the output drain window, then steps the output base.
module sa_tile_scheduler #(
  parameter int PE_SIZE    = 16,
  parameter int OC         = 64,
  parameter int TILE_WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start_i,
  input  logic [TILE_WIDTH-1:0]                       num_tile_i,
  input  logic                                        fifo_ready_i,
  input  logic                                        clear_i,
  output logic                                        en_o,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic [TILE_WIDTH-1:0]                       tile_cnt_o,
  output logic [TILE_WIDTH+$clog2(PE_SIZE*OC)-1:0]    mem0_base_o,
  output logic [2:0]                                  dbg_state_o
);

  localparam int CW = $clog2(PE_SIZE*OC);
  localparam int MW = TILE_WIDTH + CW;

  localparam logic [CW-1:0]         FILL_LAST  = CW'(PE_SIZE - 1);
  localparam logic [CW-1:0]         SKEW_LAST  = CW'(PE_SIZE - 2);
  localparam logic [CW-1:0]         DRAIN_LAST = CW'(PE_SIZE*OC - 1);
  localparam logic [TILE_WIDTH-1:0] TILE_ONE   = TILE_WIDTH'(1);
  localparam logic [MW-1:0]         BASE_STEP  = MW'(PE_SIZE*OC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FILL  = 3'd2,
    S_SKEW  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [TILE_WIDTH-1:0] num_q;
  logic [TILE_WIDTH-1:0] tile_cnt_q;
  logic [MW-1:0]         base_q;
  logic                  en_q;
  logic                  busy_q;
  logic                  done_q;

  // Outputs are registered alongside the state: each transition sets them to their
  // value in the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      tile_cnt_q <= '0;
      base_q     <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            num_q      <= num_tile_i;
            tile_cnt_q <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (num_tile_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (fifo_ready_i) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            en_q    <= 1'b1;
          end
        end
        S_FILL: begin
          if (cnt_q == FILL_LAST) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            state_q <= (PE_SIZE > 1) ? S_SKEW : S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SKEW: begin
          if (cnt_q == SKEW_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q      <= '0;
            tile_cnt_q <= tile_cnt_q + TILE_ONE;
            base_q     <= base_q + BASE_STEP;
            // Compare the incremented count so num_tile = 2^TILE_WIDTH-1 never wraps.
            if (tile_cnt_q + TILE_ONE == num_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en_o        = en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tile_cnt_o  = tile_cnt_q;
  assign mem0_base_o = base_q;
  assign dbg_state_o = state_q;

endmodule
